usb_frame_arbiter: RTL and testbench

Round-robin scheduler that shares the single USB output port among `NB_REQ` per-lane packet buffers of the BLE capture datapath. When a buffer holds a complete packet, the arbiter grants it and pops its bytes. It streams them as one framed burst on `data_o`/`valid_o`/`frame_o`, preceded by a header byte and optionally followed by an XOR checksum. It sits between the packet buffers and the USB interface and is the only driver of that interface.

---
 rtl/usb_arb_pkg.sv | 25 ++
 rtl/usb_frame_arbiter_rr_picker.sv | 30 +++
 rtl/usb_frame_arbiter.sv | 133 +++++++++++++
 tb/tb_usb_frame_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and helpers for usb_frame_arbiter.
// The CHKSUM state exists only when USB_ARB_CHKSUM_EN is defined.
package usb_arb_pkg;
    localparam int TAILLE_DATA_O = 8;
    localparam int LEN_W         = 6;
    localparam int HDR_IDX_W     = 2;
    localparam int HDR_LEN_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_GAP     = 2'd2
`ifdef USB_ARB_CHKSUM_EN
        ,
        ST_CHKSUM  = 2'd3
`endif
    } arb_state_t;

    function automatic logic [TAILLE_DATA_O-1:0] make_header(
        input logic [HDR_IDX_W-1:0] idx,
        input logic [HDR_LEN_W-1:0] len
    );
        return {idx, len};
    endfunction
endpackage

// File: rtl/usb_frame_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1.
module rr_picker
    import usb_arb_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = HDR_IDX_W
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [NB_REQ-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 1; i <= NB_REQ; i++) begin
            j = IDX_W'((int'(last) + i) % NB_REQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/usb_frame_arbiter.sv
// Round-robin framer sharing the USB byte port among NB_REQ packet buffers.
// Define USB_ARB_CHKSUM_EN to append an XOR checksum byte to every frame.
module usb_frame_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int LEN_W      = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NB_REQ-1:0]                 req_i,
    input  logic [NB_REQ*LEN_W-1:0]           len_i,
    input  logic [NB_REQ*TAILLE_DATA_O-1:0]   rd_data_i,
    output logic [NB_REQ-1:0]                 gnt_o,
    output logic [NB_REQ-1:0]                 rd_o,
    output logic [TAILLE_DATA_O-1:0]          data_o,
    output logic                              valid_o,
    output logic                              frame_o
);
    localparam int IDX_W = HDR_IDX_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t               state, state_nxt;
    logic [LEN_W-1:0]         cnt, len_q, pick_len;
    logic [GAP_W-1:0]         gap_cnt;
    logic [IDX_W-1:0]         last, idx_q, pick_idx;
    logic [NB_REQ-1:0]        pick_gnt;
    logic                     pick_any;
    logic [TAILLE_DATA_O-1:0] hdr, head_byte;
    logic                     popping;
`ifdef USB_ARB_CHKSUM_EN
    logic [TAILLE_DATA_O-1:0] xor_q;
`endif

    rr_picker #(.NB_REQ(NB_REQ), .IDX_W(IDX_W)) u_picker (
        .req  (req_i),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign pick_len  = len_i[pick_idx*LEN_W +: LEN_W];
    assign hdr       = make_header(pick_idx, pick_len[HDR_LEN_W-1:0]);
    assign head_byte = rd_data_i[idx_q*TAILLE_DATA_O +: TAILLE_DATA_O];
    assign popping   = (state == ST_PAYLOAD) && (cnt < len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pick_any) state_nxt = ST_PAYLOAD;
`ifdef USB_ARB_CHKSUM_EN
            ST_PAYLOAD: if (!popping) state_nxt = ST_CHKSUM;
            ST_CHKSUM:  state_nxt = ST_GAP;
`else
            ST_PAYLOAD: if (!popping) state_nxt = ST_GAP;
`endif
            ST_GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Pop only while a byte is actually being moved to data_o.
    always_comb begin
        rd_o = '0;
        if (popping) rd_o = gnt_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_o   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            frame_o <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
            gap_cnt <= '0;
            last    <= IDX_W'(NB_REQ - 1);
            idx_q   <= '0;
`ifdef USB_ARB_CHKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (pick_any) begin
                    gnt_o   <= pick_gnt;
                    len_q   <= pick_len;
                    idx_q   <= pick_idx;
                    last    <= pick_idx;
                    data_o  <= hdr;
                    valid_o <= 1'b1;
                    frame_o <= 1'b1;
                    cnt     <= '0;
`ifdef USB_ARB_CHKSUM_EN
                    xor_q   <= hdr;
`endif
                end
                ST_PAYLOAD: if (popping) begin
                    data_o <= head_byte;
                    cnt    <= cnt + 1'b1;
`ifdef USB_ARB_CHKSUM_EN
                    xor_q  <= xor_q ^ head_byte;
`endif
                end else begin
`ifdef USB_ARB_CHKSUM_EN
                    data_o  <= xor_q;
`else
                    gnt_o   <= '0;
                    valid_o <= 1'b0;
                    frame_o <= 1'b0;
                    gap_cnt <= '0;
`endif
                end
`ifdef USB_ARB_CHKSUM_EN
                ST_CHKSUM: begin
                    gnt_o   <= '0;
                    valid_o <= 1'b0;
                    frame_o <= 1'b0;
                    gap_cnt <= '0;
                end
`endif
                ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_frame_arbiter.sv
// Directed bench for usb_frame_arbiter; checksum expectations follow USB_ARB_CHKSUM_EN.
module tb_usb_frame_arbiter;
    localparam int NB_REQ = 4, LEN_W = 6, GAP_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [23:0] len = '0;
    logic [31:0] rd_data;
    logic [3:0]  gnt, rd;
    logic [7:0]  data;
    logic        valid, frame;

    logic [7:0]  mem [4][64];
    int          ptr [4];
    int          checks = 0, errors = 0;
    int          lows;
    logic [7:0]  exp_b, x;
    logic [7:0]  hdrs [5];
    int          lanes [5];

    always #5 clk = ~clk;

    usb_frame_arbiter #(.NB_REQ(NB_REQ), .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .rd_data_i(rd_data),
        .gnt_o(gnt), .rd_o(rd), .data_o(data), .valid_o(valid), .frame_o(frame)
    );

    // FWFT buffer model: head advances on each pop.
    always_comb
        for (int l = 0; l < 4; l++) rd_data[l*8 +: 8] = mem[l][ptr[l][5:0]];

    always @(posedge clk)
        for (int l = 0; l < 4; l++)
            if (rst)       ptr[l] <= 0;
            else if (rd[l]) ptr[l] <= ptr[l] + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(output int n_low);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame && n < 40);
        chk("frame_start", {31'd0, frame}, 32'd1);
        n_low = n - 1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        chk({tag, "_rd"}, {28'd0, rd}, 32'd0);
        chk({tag, "_data"}, {24'd0, data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_frame"}, {31'd0, frame}, 32'd0);
    endtask

    initial begin
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 64; k++) mem[l][k] = 8'((l * 64 + k) * 7 + 3);
        mem[0][0] = 8'hA1; mem[0][1] = 8'hB2; mem[0][2] = 8'hC3;

        // Reset, then single frame from buffer 0
        tick(); tick();
        chk_idle_outs("rst");
        rst = 1'b0; req = 4'b0001; len[5:0] = 6'd3;
        tick();
        chk("s_hdr", data, 8'h03);
        chk("s_hdr_vf", {valid, frame}, 2'b11);
        chk("s_gnt", gnt, 4'b0001);
        chk("s_rd0", rd, 4'b0001);
        req = 4'b0000;
        tick(); chk("s_b0", data, 8'hA1); chk("s_rd1", rd, 4'b0001);
        tick(); chk("s_b1", data, 8'hB2); chk("s_rd2", rd, 4'b0001);
        tick(); chk("s_b2", data, 8'hC3); chk("s_rd3", rd, 4'b0000);
        chk("s_b2_vf", {valid, frame}, 2'b11);
`ifdef USB_ARB_CHKSUM_EN
        tick(); chk("s_xor", data, 8'hD3); chk("s_xor_v", valid, 1'b1);
`endif
        tick();
        chk("s_end_vf", {valid, frame}, 2'b00);
        chk("s_end_gnt", gnt, 4'b0000);
        chk("s_data_hold", data, 8'hC3 `ifdef USB_ARB_CHKSUM_EN ^ 8'h10 `endif);
        chk("s_pops", ptr[0], 3);

        // All requesters held: rotation 0,1,2,3,0 after reset
        rst = 1'b1; tick(); tick();
        chk_idle_outs("rst2");
        rst = 1'b0; req = 4'b1111; len = {4{6'd1}};
        hdrs  = '{8'h01, 8'h41, 8'h81, 8'hC1, 8'h01};
        lanes = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            wait_frame(lows);
            if (i > 0) chk("rr_gap", lows, 3);
            chk("rr_hdr", data, hdrs[i]);
            chk("rr_gnt", gnt, 32'(1) << lanes[i]);
            chk("rr_rd", rd, 32'(1) << lanes[i]);
            exp_b = mem[lanes[i]][(i == 4) ? 1 : 0];
            if (i == 4) req = 4'b0000;
            tick();
            chk("rr_byte", data, exp_b);
            chk("rr_rd_off", rd, 4'b0000);
`ifdef USB_ARB_CHKSUM_EN
            tick(); chk("rr_xor", data, hdrs[i] ^ exp_b);
`endif
        end

        // Zero-length packet from buffer 2
        len[17:12] = 6'd0; req = 4'b0100;
        wait_frame(lows);
        chk("zl_gap", lows, 3);
        chk("zl_hdr", data, 8'h80);
        chk("zl_gnt", gnt, 4'b0100);
        chk("zl_rd", rd, 4'b0000);
        req = 4'b0000;
`ifdef USB_ARB_CHKSUM_EN
        tick(); chk("zl_xor", data, 8'h80); chk("zl_rd2", rd, 4'b0000);
`endif
        tick();
        chk("zl_end", {valid, frame}, 2'b00);
        chk("zl_pops", ptr[2], 1);

        // Maximum length from buffer 1; len change mid-frame ignored
        len[11:6] = 6'd63; req = 4'b0010;
        wait_frame(lows);
        chk("ml_hdr", data, 8'h7F);
        chk("ml_gnt", gnt, 4'b0010);
        x = 8'h7F;
        len[11:6] = 6'd5; req = 4'b0000;
        for (int k = 0; k < 63; k++) begin
            tick();
            chk("ml_byte", data, mem[1][k + 1]);
            x = x ^ mem[1][k + 1];
        end
        chk("ml_vf", {valid, frame}, 2'b11);
        chk("ml_rd_last", rd, 4'b0000);
`ifdef USB_ARB_CHKSUM_EN
        tick(); chk("ml_xor", data, x);
`endif
        tick();
        chk("ml_end", {valid, frame}, 2'b00);
        chk("ml_pops", ptr[1], 64);

        // Reset during payload byte 2 of a len=10 frame
        len[23:18] = 6'd10; req = 4'b1000;
        wait_frame(lows);
        chk("ra_hdr", data, 8'hCA);
        req = 4'b0000;
        tick(); tick(); tick();
        chk("ra_b2", data, mem[3][3]);
        rst = 1'b1;
        tick();
        chk_idle_outs("ra_rst");
        rst = 1'b0; req = 4'b0010; len[11:6] = 6'd2;
        wait_frame(lows);
        chk("ra_lat", lows, 0);
        chk("ra_hdr2", data, 8'h42);
        chk("ra_gnt2", gnt, 4'b0010);
        req = 4'b0000;
        tick(); chk("ra_b0", data, mem[1][0]);
        tick(); chk("ra_b1", data, mem[1][1]);
`ifdef USB_ARB_CHKSUM_EN
        tick();
`endif

        // Request swap mid-frame: buffer 0 completes, buffer 3 follows
        len[5:0] = 6'd2; len[23:18] = 6'd1; req = 4'b0001;
        wait_frame(lows);
        chk("sw_hdr0", data, 8'h02);
        chk("sw_gnt0", gnt, 4'b0001);
        req = 4'b1000;
        tick(); chk("sw_b0", data, 8'hA1); chk("sw_gnt_hold", gnt, 4'b0001);
        tick(); chk("sw_b1", data, 8'hB2);
`ifdef USB_ARB_CHKSUM_EN
        tick(); chk("sw_xor", data, 8'h02 ^ 8'hA1 ^ 8'hB2);
`endif
        wait_frame(lows);
        chk("sw_gap", lows, 3);
        chk("sw_hdr3", data, 8'hC1);
        chk("sw_gnt3", gnt, 4'b1000);
        req = 4'b0000;
        tick(); chk("sw_b3", data, mem[3][0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
